data_cache_ctrl: RTL and testbench
==================================

DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameter LINES, default 8, number of direct-mapped one-word cache lines (power of 2, 2..64).
REQ-002 Parameter IDX_W, default 3, log2(LINES); tag width = 30 - IDX_W.
REQ-003 Clk  input  1  clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset; asynchronous, active-high.
REQ-005 Addr  input  32  CPU byte address; word-aligned, bits [1:0] ignored.
REQ-006 WriteData  input  32  CPU store data.
REQ-007 MemWrite  input  1  CPU store request (MEM stage).
REQ-008 MemRead  input  1  CPU load request (MEM stage).
REQ-009 ReadData  output  32  load data; valid when MemRead=1 and MemError=0.
REQ-010 MemError  output  1  stall request to CPU; high while an access cannot complete this cycle.
REQ-011 BusAddr  output  32  backing-memory word address ({Addr[31:2],2'b00}).
REQ-012 BusWData  output  32  backing-memory write data.
REQ-013 BusReq  output  1  backing-memory request; held until BusAck.
REQ-014 BusWe  output  1  1 = write, 0 = read; valid with BusReq.
REQ-015 BusAck  input  1  one-cycle completion pulse from backing memory.
REQ-016 BusRData  input  32  read data; valid in BusAck cycle.

Function
REQ-017 Index = Addr[IDX_W+1:2]; tag = Addr[31:IDX_W+2]; hit = valid[index] and tag match.
REQ-018 FSM states: IDLE, FILL, WTHRU, DONE.
REQ-019 IDLE, MemRead=1, hit: ReadData = line data combinationally, MemError=0, stay IDLE (zero-wait hit).
REQ-020 IDLE, MemRead=1, miss: MemError=1 same cycle (combinational); next state FILL.
REQ-021 IDLE, MemWrite=1 (hit or miss): MemError=1 same cycle; next state WTHRU (write-through, every store).
REQ-022 MemWrite and MemRead both high: store takes precedence; load ignored.
REQ-023 FILL: BusReq=1, BusWe=0, MemError=1; on BusAck write BusRData, tag, valid=1 into line; next IDLE, where held load then hits.
REQ-024 WTHRU: BusReq=1, BusWe=1, BusWData=WriteData, MemError=1; on BusAck, if hit update line data (no write-allocate on miss); next DONE.
REQ-025 DONE: MemError=0 for exactly one cycle so the CPU advances; held store is not reissued; next IDLE.
REQ-026 BusReq, BusAddr, BusWe, BusWData stable from assertion until BusAck cycle inclusive; BusReq deasserts cycle after BusAck.
REQ-027 CPU holds Addr, WriteData, MemRead, MemWrite stable while MemError=1; controller latches nothing else.
REQ-028 No access (both low) in IDLE: MemError=0, ReadData=0, no bus activity.
REQ-029 BusAck outside FILL/WTHRU ignored.
REQ-030 Latency: read hit 0 stall cycles; read miss = bus latency + 1 stall cycles; store = bus latency + 1 stall cycles.

Reset
REQ-031 Rst=1: state IDLE, all valid bits 0, BusReq=0, BusWe=0, BusAddr=0, BusWData=0, ReadData=0, MemError=0 while Rst high.
REQ-032 Rst mid-FILL/WTHRU aborts transfer; line not written; pending BusAck after release ignored.
REQ-033 Data/tag arrays need no reset; only valid bits.

Structure
REQ-034 State encoding and LINES/IDX_W defaults in shared package dcache_pkg.
REQ-035 One sub-module natural: dcache_array (valid/tag/data storage, one write port, one combinational read port).

Verification
REQ-036 Cold load Addr=0x40, bus acks after 3 cycles with 0xDEADBEEF -> MemError high 4 cycles, then ReadData=0xDEADBEEF, MemError=0.
REQ-037 Repeat load Addr=0x40 -> ReadData=0xDEADBEEF same cycle, MemError=0, BusReq never asserted.
REQ-038 Store 0x12345678 to 0x40 (hit), ack after 2 cycles -> BusWe=1 write seen once, DONE cycle MemError=0, later load 0x40 hits with 0x12345678.
REQ-039 Store to 0x60 (miss, index 0 conflicts with 0x40) -> bus write issued, line 0 still holds tag of 0x40; load 0x60 then misses.
REQ-040 Rst pulse during FILL for 0x80, then BusAck -> no line valid; load 0x80 misses again.
REQ-041 MemRead and MemWrite both high at 0x44 -> only bus write occurs, no fill.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache controller.
package dcache_pkg;

    localparam int DCACHE_LINES = 8;
    localparam int DCACHE_IDX_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WTHRU = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // A 32-bit word address leaves 30 bits, split between index and tag.
    function automatic int tag_width(input int idx_w);
        return 30 - idx_w;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one write port and one combinational read port on a shared index.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = DCACHE_LINES,
    parameter int IDX_W = DCACHE_IDX_W,
    parameter int TAG_W = tag_width(IDX_W)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [IDX_W-1:0] idx,
    input  logic             we,
    input  logic [TAG_W-1:0] wtag,
    input  logic [31:0]      wdata,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      data_d [LINES];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[idx] = 1'b1;
            tag_d[idx]   = wtag;
            data_d[idx]  = wdata;
        end
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // NOTE: tag/data are never read while their valid bit is clear, so they carry no reset.
    always_ff @(posedge Clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped one-word-line data cache: zero-wait read hits, fill on miss, write-through stores.
module data_cache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = DCACHE_LINES,
    parameter int IDX_W = DCACHE_IDX_W
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        MemError,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic        BusReq,
    output logic        BusWe,
    input  logic        BusAck,
    input  logic [31:0] BusRData
);

    localparam int TAG_W = tag_width(IDX_W);

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_data;
    logic             hit;
    logic             arr_we;
    logic [31:0]      arr_wdata;
    logic             unused_addr_lsbs;

    assign idx              = Addr[IDX_W+1:2];
    assign tag              = Addr[31:IDX_W+2];
    assign hit              = line_valid && (line_tag == tag);
    assign unused_addr_lsbs = ^Addr[1:0];

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .Clk      (Clk),
        .Rst      (Rst),
        .idx      (idx),
        .we       (arr_we),
        .wtag     (tag),
        .wdata    (arr_wdata),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        arr_we      = 1'b0;
        arr_wdata   = BusRData;
        MemError    = 1'b0;
        ReadData    = '0;
        // Rst is asynchronous, so the CPU-facing outputs are forced quiet while it is high.
        if (!Rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (MemWrite) begin
                        MemError    = 1'b1;
                        state_d     = S_WTHRU;
                        bus_req_d   = 1'b1;
                        bus_we_d    = 1'b1;
                        bus_addr_d  = {Addr[31:2], 2'b00};
                        bus_wdata_d = WriteData;
                    end else if (MemRead) begin
                        if (hit) begin
                            ReadData = line_data;
                        end else begin
                            MemError    = 1'b1;
                            state_d     = S_FILL;
                            bus_req_d   = 1'b1;
                            bus_we_d    = 1'b0;
                            bus_addr_d  = {Addr[31:2], 2'b00};
                            bus_wdata_d = '0;
                        end
                    end
                end
                S_FILL: begin
                    MemError = 1'b1;
                    if (BusAck) begin
                        arr_we    = 1'b1;
                        bus_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                S_WTHRU: begin
                    MemError = 1'b1;
                    if (BusAck) begin
                        // No write-allocate: a store only touches a line it already owns.
                        arr_we    = hit;
                        arr_wdata = WriteData;
                        bus_req_d = 1'b0;
                        bus_we_d  = 1'b0;
                        state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign BusReq   = bus_req_q;
    assign BusWe    = bus_we_q;
    assign BusAddr  = bus_addr_q;
    assign BusWData = bus_wdata_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl: a cache model predicts data and stall counts per access.
module tb_data_cache_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Addr, WriteData;
    logic        MemWrite, MemRead;
    logic [31:0] ReadData;
    logic        MemError;
    logic [31:0] BusAddr, BusWData;
    logic        BusReq, BusWe;
    logic        BusAck = 1'b0;
    logic [31:0] BusRData = '0;

    int checks = 0;
    int errors = 0;

    int          ack_delay = 1;
    logic [31:0] bus_rdata_val = '0;
    bit          stray_ack = 1'b0;
    int          bus_cnt = 0;
    int          rd_reqs = 0;
    int          wr_reqs = 0;
    logic [31:0] req_addr, req_wdata;
    logic        req_we;

    typedef struct {
        bit          is_load;
        bit          bus_rd;
        bit          bus_wr;
        logic [31:0] data;
        int          stalls;
    } exp_t;
    exp_t exp_q[$];

    bit          mdl_valid [8];
    logic [26:0] mdl_tag   [8];
    logic [31:0] mdl_data  [8];

    data_cache_ctrl dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .MemError  (MemError),
        .BusAddr   (BusAddr),
        .BusWData  (BusWData),
        .BusReq    (BusReq),
        .BusWe     (BusWe),
        .BusAck    (BusAck),
        .BusRData  (BusRData)
    );

    always #5 Clk = ~Clk;

    // Backing memory: acks the ack_delay-th cycle of a request and checks the request stays stable.
    always @(posedge Clk) begin
        #1;
        BusAck = 1'b0;
        if (stray_ack) begin
            BusAck    = 1'b1;
            stray_ack = 1'b0;
        end else if (BusReq) begin
            if (bus_cnt == 0) begin
                req_addr  = BusAddr;
                req_we    = BusWe;
                req_wdata = BusWData;
                if (BusWe) wr_reqs++;
                else       rd_reqs++;
            end else begin
                checks++;
                if ({BusAddr, BusWe, BusWData} !== {req_addr, req_we, req_wdata}) begin
                    errors++;
                    $display("FAIL bus_stable: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                             BusAddr, BusWe, BusWData, req_addr, req_we, req_wdata);
                end
            end
            bus_cnt++;
            if (bus_cnt == ack_delay) begin
                BusAck   = 1'b1;
                BusRData = bus_rdata_val;
            end
        end else begin
            bus_cnt = 0;
        end
    end

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input string name);
        exp_t        e;
        int          idx;
        logic [26:0] tag;
        bit          hit;
        int          rd0, wr0, stalls;
        idx = int'(addr[4:2]);
        tag = addr[31:5];
        hit = mdl_valid[idx] && (mdl_tag[idx] == tag);
        e.is_load = rd && !wr;
        e.bus_wr  = wr;
        e.bus_rd  = e.is_load && !hit;
        e.data    = '0;
        e.stalls  = 0;
        if (wr) begin
            e.stalls = ack_delay + 1;
            if (hit) mdl_data[idx] = wdata;
        end else if (rd) begin
            if (hit) begin
                e.data = mdl_data[idx];
            end else begin
                e.stalls       = ack_delay + 1;
                e.data         = bus_rdata_val;
                mdl_valid[idx] = 1'b1;
                mdl_tag[idx]   = tag;
                mdl_data[idx]  = bus_rdata_val;
            end
        end
        exp_q.push_back(e);
        rd0 = rd_reqs;
        wr0 = wr_reqs;

        @(posedge Clk);
        #1;
        Addr      = addr;
        WriteData = wdata;
        MemRead   = rd;
        MemWrite  = wr;
        stalls    = 0;
        forever begin
            @(negedge Clk);
            if (!MemError) break;
            stalls++;
            if (stalls > 40) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: MemError still high after %0d cycles, required low", name, stalls);
                break;
            end
        end

        e = exp_q.pop_front();
        checks++;
        if (stalls != e.stalls) begin
            errors++;
            $display("FAIL %s_stalls: got %0d, required %0d", name, stalls, e.stalls);
        end
        if (e.is_load) begin
            checks++;
            if (ReadData !== e.data) begin
                errors++;
                $display("FAIL %s_data: got %h, required %h", name, ReadData, e.data);
            end
        end
        checks++;
        if (rd_reqs != rd0 + int'(e.bus_rd) || wr_reqs != wr0 + int'(e.bus_wr)) begin
            errors++;
            $display("FAIL %s_bus_count: got rd=%0d wr=%0d, required rd=%0d wr=%0d",
                     name, rd_reqs - rd0, wr_reqs - wr0, int'(e.bus_rd), int'(e.bus_wr));
        end
        if (e.bus_rd || e.bus_wr) begin
            checks++;
            if (req_addr !== {addr[31:2], 2'b00} || req_we !== e.bus_wr ||
                (e.bus_wr && req_wdata !== wdata)) begin
                errors++;
                $display("FAIL %s_bus_req: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                         name, req_addr, req_we, req_wdata, {addr[31:2], 2'b00}, e.bus_wr, wdata);
            end
        end

        @(posedge Clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        Rst       = 1'b1;
        Addr      = 32'h40;
        WriteData = '0;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        foreach (mdl_valid[i]) mdl_valid[i] = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({MemError, BusReq, BusWe} !== 3'b000 || ReadData !== '0 ||
            BusAddr !== '0 || BusWData !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got err=%b req=%b we=%b rd=%h addr=%h wd=%h, required all zero",
                     MemError, BusReq, BusWe, ReadData, BusAddr, BusWData);
        end
        MemRead = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (MemError !== 1'b0 || ReadData !== '0 || BusReq !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_access: got err=%b rd=%h req=%b, required 0 0 0", MemError, ReadData, BusReq);
        end
    endtask

    task automatic test_cold_load();
        ack_delay     = 3;
        bus_rdata_val = 32'hDEADBEEF;
        do_access(1'b1, 1'b0, 32'h40, '0, "cold_load");
    endtask

    task automatic test_hit_load();
        bus_rdata_val = 32'h0;
        do_access(1'b1, 1'b0, 32'h40, '0, "hit_load");
        do_access(1'b1, 1'b0, 32'h43, '0, "hit_load_lsbs");
    endtask

    task automatic test_store_hit();
        int wr0;
        ack_delay = 2;
        do_access(1'b0, 1'b1, 32'h40, 32'h12345678, "store_hit");
        wr0 = wr_reqs;
        repeat (4) @(negedge Clk);
        checks++;
        if (wr_reqs != wr0 || BusReq !== 1'b0) begin
            errors++;
            $display("FAIL store_no_reissue: got extra=%0d req=%b, required 0 0", wr_reqs - wr0, BusReq);
        end
        do_access(1'b1, 1'b0, 32'h40, '0, "load_after_store");
    endtask

    task automatic test_store_miss();
        do_access(1'b0, 1'b1, 32'h60, 32'hAABBCCDD, "store_miss");
        do_access(1'b1, 1'b0, 32'h40, '0, "line0_kept");
        ack_delay     = 1;
        bus_rdata_val = 32'h0BADF00D;
        do_access(1'b1, 1'b0, 32'h60, '0, "load_60_miss");
    endtask

    task automatic test_read_write_both();
        ack_delay     = 1;
        bus_rdata_val = 32'h77665544;
        do_access(1'b1, 1'b1, 32'h44, 32'h55AA55AA, "rd_wr_both");
        do_access(1'b1, 1'b0, 32'h44, '0, "load_44_miss");
    endtask

    task automatic test_reset_mid_fill();
        ack_delay     = 10;
        bus_rdata_val = 32'hFEEDFACE;
        @(posedge Clk);
        #1;
        Addr    = 32'h80;
        MemRead = 1'b1;
        repeat (3) @(posedge Clk);
        #2;
        Rst = 1'b1;
        @(negedge Clk);
        checks++;
        if (MemError !== 1'b0 || BusReq !== 1'b0 || ReadData !== '0) begin
            errors++;
            $display("FAIL reset_mid_fill: got err=%b req=%b rd=%h, required 0 0 0", MemError, BusReq, ReadData);
        end
        MemRead = 1'b0;
        @(posedge Clk);
        #2;
        Rst       = 1'b0;
        stray_ack = 1'b1;
        foreach (mdl_valid[i]) mdl_valid[i] = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (BusReq !== 1'b0 || MemError !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: got req=%b err=%b, required 0 0", BusReq, MemError);
        end
        ack_delay     = 2;
        bus_rdata_val = 32'hCAFEF00D;
        do_access(1'b1, 1'b0, 32'h80, '0, "load_80_after_rst");
        bus_rdata_val = 32'h13579BDF;
        do_access(1'b1, 1'b0, 32'h44, '0, "load_44_after_rst");
        do_access(1'b1, 1'b0, 32'h80, '0, "load_80_hit");
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_hit_load();
        test_store_hit();
        test_store_miss();
        test_read_write_both();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
